// File: rtl/xif_mem_read_arbiter.sv
// Round-robin arbiter sharing one X-interface memory read port among NUM_REQ requesters.
// One transaction in flight; optional response timeout completes with an error.
module xif_mem_read_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        done_o,
    output logic                      err_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      busy_o,
    output logic                      mem_valid_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    input  logic                      mem_ready_i,
    input  logic                      mem_result_valid_i,
    input  logic [DATA_W-1:0]         mem_result_rdata_i,
    input  logic                      mem_result_err_i
);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, RESP} state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d, sel_q, sel_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  gnt_d, done_d;
    logic                err_d, busy_d, mem_valid_d;
    logic [DATA_W-1:0]   rdata_d;
    logic [ADDR_W-1:0]   mem_addr_d, addr_win;

    logic [PTR_W-1:0]    win;
    logic                win_vld;
    logic [PTR_W:0]      cand;

    // First asserted request at or above ptr_q, wrapping past NUM_REQ-1.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(NUM_REQ)) cand = cand - (PTR_W+1)'(NUM_REQ);
            if (!win_vld && req_i[cand[PTR_W-1:0]]) begin
                win     = cand[PTR_W-1:0];
                win_vld = 1'b1;
            end
        end
    end

    assign addr_win = addr_i[int'(win)*ADDR_W +: ADDR_W];

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        gnt_d       = '0;
        done_d      = '0;
        err_d       = 1'b0;
        rdata_d     = rdata_o;
        mem_valid_d = mem_valid_o;
        mem_addr_d  = mem_addr_o;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d     = ISSUE;
                    sel_d       = win;
                    gnt_d       = NUM_REQ'(1) << win;
                    mem_valid_d = 1'b1;
                    mem_addr_d  = addr_win;
                end
            end
            ISSUE: begin
                if (mem_ready_i) begin
                    state_d     = WAIT_RESP;
                    mem_valid_d = 1'b0;
                    cnt_d       = '0;
                end
            end
            WAIT_RESP: begin
                // A result arriving in the expiry cycle still counts as a normal completion.
                if (mem_result_valid_i) begin
                    state_d = RESP;
                    done_d  = NUM_REQ'(1) << sel_q;
                    err_d   = mem_result_err_i;
                    rdata_d = mem_result_rdata_i;
                end else if (TIMEOUT_CYC != 0 && cnt_q == CNT_LAST) begin
                    state_d = RESP;
                    done_d  = NUM_REQ'(1) << sel_q;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                ptr_d   = (sel_q == PTR_W'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            sel_q       <= '0;
            cnt_q       <= '0;
            gnt_o       <= '0;
            done_o      <= '0;
            err_o       <= 1'b0;
            rdata_o     <= '0;
            busy_o      <= 1'b0;
            mem_valid_o <= 1'b0;
            mem_addr_o  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            gnt_o       <= gnt_d;
            done_o      <= done_d;
            err_o       <= err_d;
            rdata_o     <= rdata_d;
            busy_o      <= busy_d;
            mem_valid_o <= mem_valid_d;
            mem_addr_o  <= mem_addr_d;
        end
    end
endmodule

// File: tb/tb_xif_mem_read_arbiter.sv
// Bench for xif_mem_read_arbiter: scripted memory responder plus a queue of expected completions.
module tb_xif_mem_read_arbiter;
    localparam int NR = 4;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic [NR-1:0]   req_i;
    logic [NR*32-1:0] addr_i;
    logic [NR-1:0]   gnt_o, done_o;
    logic            err_o, busy_o, mem_valid_o;
    logic [31:0]     rdata_o, mem_addr_o;
    logic            mem_ready_i, mem_result_valid_i, mem_result_err_i;
    logic [31:0]     mem_result_rdata_i;

    xif_mem_read_arbiter #(.NUM_REQ(NR), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .addr_i(addr_i),
        .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o), .busy_o(busy_o),
        .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o), .mem_ready_i(mem_ready_i),
        .mem_result_valid_i(mem_result_valid_i), .mem_result_rdata_i(mem_result_rdata_i),
        .mem_result_err_i(mem_result_err_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { int idx; logic err; logic [31:0] data; } exp_t;
    exp_t sb[$];

    int n_cmp = 0, n_fail = 0;
    int cyc = 0, hs_cnt = 0;
    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        if (mem_valid_o && mem_ready_i) hs_cnt <= hs_cnt + 1;
    end

    // Memory responder configuration
    bit          rsp_en = 1'b1, rsp_use_fixed = 1'b0, rsp_err = 1'b0;
    logic [31:0] rsp_fixed = '0;
    int          ready_delay = 0, resp_delay = 0;
    logic [31:0] seen_addr;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    initial begin
        mem_ready_i = 1'b0; mem_result_valid_i = 1'b0;
        mem_result_rdata_i = '0; mem_result_err_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (mem_valid_o) begin
                seen_addr = mem_addr_o;
                repeat (ready_delay) @(negedge clk_i);
                mem_ready_i = 1'b1;
                @(negedge clk_i);
                mem_ready_i = 1'b0;
                if (rsp_en) begin
                    repeat (resp_delay) @(negedge clk_i);
                    mem_result_valid_i = 1'b1;
                    mem_result_rdata_i = rsp_use_fixed ? rsp_fixed : mem_data(seen_addr);
                    mem_result_err_i   = rsp_err;
                    @(negedge clk_i);
                    mem_result_valid_i = 1'b0;
                    mem_result_rdata_i = '0;
                    mem_result_err_i   = 1'b0;
                end
            end
        end
    end

    task automatic set_addr(input int k, input logic [31:0] a);
        addr_i[k*32 +: 32] = a;
    endtask

    task automatic wait_gnt(output logic [NR-1:0] g, output bit ok);
        ok = 1'b0; g = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_i);
            if (gnt_o != '0) begin g = gnt_o; ok = 1'b1; break; end
        end
    endtask

    task automatic wait_done(output logic [NR-1:0] d, output logic e, output logic [31:0] r,
                             output bit ok);
        ok = 1'b0; d = '0; e = 1'b0; r = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_i);
            if (done_o != '0) begin d = done_o; e = err_o; r = rdata_o; ok = 1'b1; break; end
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0; req_i = '0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; req_i = '0; addr_i = '0;
        repeat (3) @(negedge clk_i);
        n_cmp++;
        if ({gnt_o, done_o, err_o, rdata_o, busy_o, mem_valid_o, mem_addr_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: gnt=%b done=%b err=%b rdata=%h busy=%b valid=%b addr=%h, required all 0",
                     gnt_o, done_o, err_o, rdata_o, busy_o, mem_valid_o, mem_addr_o);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_single();
        logic [NR-1:0] g, d; logic e; logic [31:0] r; bit ok; exp_t x;
        rsp_use_fixed = 1'b1; rsp_fixed = 32'hDEADBEEF; resp_delay = 2;
        set_addr(2, 32'h0000_1000); req_i = 4'b0100;
        sb.push_back('{2, 1'b0, 32'hDEADBEEF});
        wait_gnt(g, ok);
        req_i[2] = 1'b0;
        n_cmp++;
        if (!ok || g !== 4'b0100 || mem_valid_o !== 1'b1 || mem_addr_o !== 32'h1000) begin
            n_fail++;
            $display("FAIL single_gnt: ok=%0b gnt=%b valid=%b addr=%h, required gnt=0100 valid=1 addr=00001000",
                     ok, g, mem_valid_o, mem_addr_o);
        end
        wait_done(d, e, r, ok);
        x = sb.pop_front();
        n_cmp++;
        if (!ok || d !== NR'(1 << x.idx) || e !== x.err || r !== x.data) begin
            n_fail++;
            $display("FAIL single_done: ok=%0b done=%b err=%b rdata=%h, required done=%b err=%b rdata=%h",
                     ok, d, e, r, NR'(1 << x.idx), x.err, x.data);
        end
        @(negedge clk_i);
        n_cmp++;
        if (done_o !== '0 || err_o !== 1'b0 || rdata_o !== x.data || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_after: done=%b err=%b rdata=%h busy=%b, required done=0 err=0 rdata=%h busy=0",
                     done_o, err_o, rdata_o, busy_o, x.data);
        end
        rsp_use_fixed = 1'b0; resp_delay = 0;
    endtask

    task automatic test_back_to_back();
        logic [NR-1:0] g, d; logic e; logic [31:0] r; bit ok; exp_t x;
        int last_cyc;
        int order[6] = '{0, 1, 2, 3, 0, 3};
        do_reset();
        for (int k = 0; k < NR; k++) set_addr(k, 32'h0000_2000 + 32'(k * 16));
        req_i = 4'b1111;
        for (int i = 0; i < 4; i++)
            sb.push_back('{order[i], 1'b0, mem_data(32'h0000_2000 + 32'(order[i] * 16))});
        last_cyc = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) begin
                req_i = 4'b1001;
                for (int j = 4; j < 6; j++)
                    sb.push_back('{order[j], 1'b0, mem_data(32'h0000_2000 + 32'(order[j] * 16))});
            end
            x = sb.pop_front();
            wait_gnt(g, ok);
            req_i = req_i & ~g;
            n_cmp++;
            if (!ok || g !== NR'(1 << x.idx)) begin
                n_fail++;
                $display("FAIL rr_gnt[%0d]: ok=%0b gnt=%b, required %b", i, ok, g, NR'(1 << x.idx));
            end
            if (i > 0 && i < 4) begin
                n_cmp++;
                if (cyc - last_cyc !== 4) begin
                    n_fail++;
                    $display("FAIL b2b_spacing[%0d]: %0d cycles, required 4", i, cyc - last_cyc);
                end
            end
            last_cyc = cyc;
            wait_done(d, e, r, ok);
            n_cmp++;
            if (!ok || d !== NR'(1 << x.idx) || e !== 1'b0 || r !== x.data) begin
                n_fail++;
                $display("FAIL rr_done[%0d]: ok=%0b done=%b err=%b rdata=%h, required done=%b err=0 rdata=%h",
                         i, ok, d, e, r, NR'(1 << x.idx), x.data);
            end
        end
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_stall();
        logic [NR-1:0] g, d; logic e; logic [31:0] r; bit ok; exp_t x; int hs0;
        int bad = 0;
        ready_delay = 5;
        set_addr(1, 32'h0000_3330); req_i = 4'b0010;
        sb.push_back('{1, 1'b0, mem_data(32'h0000_3330)});
        hs0 = hs_cnt;
        wait_gnt(g, ok);
        req_i = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            if (mem_valid_o !== 1'b1 || mem_addr_o !== 32'h3330 || gnt_o !== '0) bad++;
        end
        n_cmp++;
        if (!ok || bad != 0) begin
            n_fail++;
            $display("FAIL stall_hold: ok=%0b unstable_cycles=%0d, required 0", ok, bad);
        end
        wait_done(d, e, r, ok);
        x = sb.pop_front();
        n_cmp++;
        if (!ok || d !== NR'(1 << x.idx) || r !== x.data || hs_cnt - hs0 !== 1) begin
            n_fail++;
            $display("FAIL stall_done: ok=%0b done=%b rdata=%h handshakes=%0d, required done=%b rdata=%h handshakes=1",
                     ok, d, r, hs_cnt - hs0, NR'(1 << x.idx), x.data);
        end
        ready_delay = 0;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_mem_err();
        logic [NR-1:0] g, d; logic e; logic [31:0] r; bit ok; exp_t x;
        rsp_err = 1'b1; resp_delay = 1;
        set_addr(3, 32'h0000_4444); req_i = 4'b1000;
        sb.push_back('{3, 1'b1, mem_data(32'h0000_4444)});
        wait_gnt(g, ok);
        req_i = '0;
        wait_done(d, e, r, ok);
        x = sb.pop_front();
        n_cmp++;
        if (!ok || d !== NR'(1 << x.idx) || e !== x.err || r !== x.data) begin
            n_fail++;
            $display("FAIL mem_err: ok=%0b done=%b err=%b rdata=%h, required done=%b err=1 rdata=%h",
                     ok, d, e, r, NR'(1 << x.idx), x.data);
        end
        rsp_err = 1'b0; resp_delay = 0;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_timeout();
        logic [NR-1:0] g, d; logic e; logic [31:0] r; bit ok; exp_t x; int bad = 0;
        resp_delay = 10;
        set_addr(0, 32'h0000_5550); req_i = 4'b0001;
        sb.push_back('{0, 1'b1, 32'h0});
        wait_gnt(g, ok);
        req_i = '0;
        wait_done(d, e, r, ok);
        x = sb.pop_front();
        n_cmp++;
        if (!ok || d !== NR'(1 << x.idx) || e !== x.err || r !== x.data) begin
            n_fail++;
            $display("FAIL timeout_done: ok=%0b done=%b err=%b rdata=%h, required done=%b err=1 rdata=0",
                     ok, d, e, r, NR'(1 << x.idx));
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            if (i > 0 && (busy_o !== 1'b0 || done_o !== '0 || mem_valid_o !== 1'b0)) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL late_result_ignored: %0d disturbed cycles, required 0", bad);
        end
        resp_delay = 0;
    endtask

    task automatic test_expiry_result();
        logic [NR-1:0] g, d; logic e; logic [31:0] r; bit ok; exp_t x;
        resp_delay = 7;
        set_addr(2, 32'h0000_6660); req_i = 4'b0100;
        sb.push_back('{2, 1'b0, mem_data(32'h0000_6660)});
        wait_gnt(g, ok);
        req_i = '0;
        wait_done(d, e, r, ok);
        x = sb.pop_front();
        n_cmp++;
        if (!ok || d !== NR'(1 << x.idx) || e !== x.err || r !== x.data) begin
            n_fail++;
            $display("FAIL expiry_result: ok=%0b done=%b err=%b rdata=%h, required done=%b err=0 rdata=%h",
                     ok, d, e, r, NR'(1 << x.idx), x.data);
        end
        resp_delay = 0;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_reset_in_wait();
        logic [NR-1:0] g, d; logic e; logic [31:0] r; bit ok; exp_t x; int bad = 0;
        // Complete on requester 1 so the pointer moves to 2 before the abort.
        set_addr(1, 32'h0000_7770); set_addr(2, 32'h0000_7780); set_addr(3, 32'h0000_7790);
        req_i = 4'b0010;
        wait_gnt(g, ok);
        req_i = '0;
        wait_done(d, e, r, ok);
        repeat (2) @(negedge clk_i);
        rsp_en = 1'b0;
        req_i = 4'b0100;
        wait_gnt(g, ok);
        req_i = '0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        n_cmp++;
        if ({gnt_o, done_o, err_o, rdata_o, busy_o, mem_valid_o, mem_addr_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_in_wait: gnt=%b done=%b err=%b rdata=%h busy=%b valid=%b addr=%h, required all 0",
                     gnt_o, done_o, err_o, rdata_o, busy_o, mem_valid_o, mem_addr_o);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            if (done_o !== '0 || busy_o !== 1'b0) bad++;
        end
        rst_ni = 1'b1;
        rsp_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            if (done_o !== '0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL no_done_after_reset: %0d bad cycles, required 0", bad);
        end
        req_i = 4'b1010;
        sb.push_back('{1, 1'b0, mem_data(32'h0000_7770)});
        wait_gnt(g, ok);
        req_i = req_i & ~g;
        x = sb.pop_front();
        n_cmp++;
        if (!ok || g !== NR'(1 << x.idx)) begin
            n_fail++;
            $display("FAIL ptr_after_reset: ok=%0b gnt=%b, required %b", ok, g, NR'(1 << x.idx));
        end
        wait_done(d, e, r, ok);
        n_cmp++;
        if (!ok || d !== NR'(1 << x.idx) || r !== x.data) begin
            n_fail++;
            $display("FAIL ptr_after_reset_done: ok=%0b done=%b rdata=%h, required done=%b rdata=%h",
                     ok, d, r, NR'(1 << x.idx), x.data);
        end
        wait_gnt(g, ok);
        req_i = '0;
        wait_done(d, e, r, ok);
        repeat (2) @(negedge clk_i);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_mem_err();
        test_timeout();
        test_expiry_result();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion before 200000");
        $fatal(1);
    end
endmodule
